// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one result per valid/ready request.
// The last result is held on o_bcd/o_ovf until the next completion or reset.
module bin2bcd_seq #(
    parameter int unsigned IN_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    input  logic [IN_WIDTH-1:0] i_bin,
    output logic                o_ready,
    output logic                o_valid,
    output logic [15:0]         o_bcd,
    output logic                o_ovf
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [19:0]         scratch_q, scratch_d;
    logic [19:0]         scratch_adj, scratch_shl;
    logic [4:0]          cnt_q, cnt_d;
    logic [15:0]         bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;

    // Add-3 correction per digit, then shift one binary bit into the scratch.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_shl = {scratch_adj[18:0], shift_q[IN_WIDTH-1]};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    shift_d   = i_bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shift_d   = shift_q << 1;
                scratch_d = scratch_shl;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'(IN_WIDTH - 1)) begin
                    bcd_d   = scratch_shl[15:0];
                    ovf_d   = |scratch_shl[19:16];
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign o_ready = (state_q == StIdle);
    assign o_valid = valid_q;
    assign o_bcd   = bcd_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random values against a decimal model,
// and hand-written busy, back-to-back and reset sequences.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_bin = '0;
    logic        o_ready, o_valid, o_ovf;
    logic [15:0] o_bcd;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    logic        mon_en = 1'b0;
    logic        last_rst = 1'b0;
    logic [16:0] prev_out = '0;

    bin2bcd_seq #(.IN_WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(i_valid),
        .i_bin  (i_bin),
        .o_ready(o_ready),
        .o_valid(o_valid),
        .o_bcd  (o_bcd),
        .o_ovf  (o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned v;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decimal model: digits of (v mod 10000) by plain arithmetic, overflow when v > 9999.
    function automatic logic [16:0] model(input int unsigned v);
        int unsigned m;
        m = v % 10000;
        model = {v > 9999, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    always @(posedge clk) last_rst = rst_n;

    // Continuous checks: valid pulse count, output hold between completions, digit range.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid) vcount++;
            if (!o_valid && last_rst) chk("hold", {15'd0, o_ovf, o_bcd}, {15'd0, prev_out});
            for (int i = 0; i < 4; i++) begin
                if (o_bcd[4*i +: 4] > 4'd9) chk("digit_range", 32'(o_bcd), 32'h9999);
            end
            prev_out = {o_ovf, o_bcd};
        end
    end

    task automatic do_conv(input int unsigned v, input logic [15:0] exp_bcd, input logic exp_ovf,
                           input string name);
        int  n;
        logic busy_ok;
        busy_ok = 1'b1;
        i_bin   = v[15:0];
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        for (n = 0; n < 40; n++) begin
            if (o_valid) break;
            if (o_ready) busy_ok = 1'b0;
            step();
        end
        chk({name, "_latency"}, 32'(n), 32'd16);
        chk({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({name, "_ready_at_valid"}, {31'd0, o_ready}, 32'd1);
        chk({name, "_bcd"}, 32'(o_bcd), 32'(exp_bcd));
        chk({name, "_ovf"}, {31'd0, o_ovf}, {31'd0, exp_ovf});
        step();
        chk({name, "_pulse"}, {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        vec_t        tbl[7];
        int unsigned r;
        logic [16:0] m;
        int          v0, k;
        int          times[3];
        int unsigned bb[3];

        tbl[0] = '{1234,  16'h1234, 1'b0};
        tbl[1] = '{0,     16'h0000, 1'b0};
        tbl[2] = '{9,     16'h0009, 1'b0};
        tbl[3] = '{10,    16'h0010, 1'b0};
        tbl[4] = '{9999,  16'h9999, 1'b0};
        tbl[5] = '{10000, 16'h0000, 1'b1};
        tbl[6] = '{65535, 16'h5535, 1'b1};
        bb[0] = 100; bb[1] = 200; bb[2] = 300;

        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_out", {15'd0, o_ovf, o_bcd}, 32'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) do_conv(tbl[i].v, tbl[i].bcd, tbl[i].ovf, "table");

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 65535);
            m = model(r);
            do_conv(r, m[15:0], m[16], "random");
        end

        // Request while busy is ignored; result then held through idle cycles.
        v0 = vcount;
        i_bin = 16'd4321;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (3) step();
        i_bin = 16'd7777;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        i_bin = '0;
        repeat (64) step();
        chk("busy_pulses", 32'(vcount - v0), 32'd1);
        chk("busy_bcd", 32'(o_bcd), 32'h4321);
        chk("busy_ready", {31'd0, o_ready}, 32'd1);

        // Back-to-back with i_valid held high.
        v0 = vcount;
        k = 0;
        i_bin = 16'(bb[0]);
        i_valid = 1'b1;
        for (int c = 0; c < 120 && k < 3; c++) begin
            step();
            if (o_valid) begin
                m = model(bb[k]);
                chk("b2b_bcd", 32'(o_bcd), 32'(m[15:0]));
                times[k] = c;
                k++;
                if (k < 3) i_bin = 16'(bb[k]);
                else i_valid = 1'b0;
            end
        end
        chk("b2b_count", 32'(k), 32'd3);
        chk("b2b_period1", 32'(times[1] - times[0]), 32'd17);
        chk("b2b_period2", 32'(times[2] - times[1]), 32'd17);
        repeat (20) step();
        chk("b2b_pulses", 32'(vcount - v0), 32'd3);

        // Reset in the middle of a conversion.
        do_conv(42, 16'h0042, 1'b0, "pre_rst");
        v0 = vcount;
        i_bin = 16'd5678;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_out", {15'd0, o_ovf, o_bcd}, 32'd0);
        chk("midrst_ready", {31'd0, o_ready}, 32'd1);
        repeat (20) step();
        chk("midrst_pulses", 32'(vcount - v0), 32'd0);
        do_conv(42, 16'h0042, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
